imem_ctrl: RTL and testbench
============================

// Module: imem_ctrl
// PURPOSE
//  Instruction-memory responder for the fetch stage: accepts the PC on
//  imem_addr, returns the instruction word on imem_data, raises stall while
//  the word is unavailable. Direct-mapped, one-word-per-line instruction cache
//  in front of a variable-latency req/ack backing bus. Sits between fetch and
//  the system memory port.
// PARAMETERS
//  LINES    16  cache lines, power of two >= 2; IDX_W = log2(LINES)
//  RST_DATA 0   value of imem_data whenever stall is high
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   reset, asynchronous, active-low
//  imem_addr  in   32  fetch address (PC); bits [1:0] ignored
//  inv        in   1   invalidate-all pulse
//  imem_data  out  32  instruction word, valid when stall low
//  stall      out  1   word not available this cycle; fetch must hold PC
//  bus_req    out  1   backing-memory read request (registered)
//  bus_addr   out  32  word-aligned read address (registered)
//  bus_ack    in   1   read data valid on bus_rdata, single-cycle pulse
//  bus_rdata  in   32  read data
// BEHAVIOUR
//  - Decode: idx = imem_addr[IDX_W+1:2], tag = imem_addr[31:IDX_W+2].
//  - hit = (state==IDLE) & valid[idx] & (tag_q[idx]==tag); combinational.
//  - stall = ~hit; imem_data = hit ? data_q[idx] : RST_DATA.
//  - FSM IDLE: miss -> latch {imem_addr[31:2],2'b00} into bus_addr, bus_req<=1,
//    go FILL. Hit -> stay IDLE, bus untouched.
//  - FSM FILL: bus_req/bus_addr held stable until bus_ack. On bus_ack: write
//    valid/tag/data for latched address (unless inv_pend), bus_req<=0, go IDLE.
//  - Min miss penalty 2 stall cycles (miss cycle, FILL cycle with ack); ack
//    N cycles after bus_req rises -> N+2 stall cycles; hit next cycle.
//  - bus_ack outside FILL ignored. No timeout; fill waits indefinitely.
//  - imem_addr change during FILL: fill completes for latched address; lookup
//    after return uses the current imem_addr (may miss again).
//  - inv: all valid bits cleared at next edge; lookup in the inv cycle uses
//    pre-clear state. inv in FILL (or in the IDLE cycle launching the fill) sets
//    inv_pend: fill completes handshake, line not written; inv_pend cleared
//    on leaving FILL.
//  - Reset (async, any state incl. mid-fill): state=IDLE, valid=0,
//    inv_pend=0, bus_req=0, bus_addr=0; hence stall=1, imem_data=RST_DATA.
//    Tag/data arrays not reset.
// CONFIGURATION
//  IMEM_PERF_EN defined: adds outputs hit_count[31:0], miss_count[31:0];
//    hit_count +1 each cycle hit=1, miss_count +1 on each IDLE->FILL;
//    both saturate at 32'hFFFF_FFFF, reset to 0, not cleared by inv.
//  IMEM_PERF_EN undefined: ports and counters absent; behaviour otherwise same.
// TESTING
//  1 reset release, imem_addr=0x0, ack 3 cyc after req with 0xDEADBEEF ->
//    stall cyc0-4, bus_addr=0x0, imem_data=0xDEADBEEF stall=0 cyc5
//  2 re-present 0x0 -> stall=0 same cycle, imem_data=0xDEADBEEF, bus_req stays 0
//  3 imem_addr=0x40 (idx0, new tag), fill 0x12345678 -> line replaced;
//    back to 0x0 -> miss, new bus_req with bus_addr=0x0
//  4 imem_addr=0x7 on miss, ack same cycle bus_req rises -> bus_addr=0x4,
//    exactly 2 stall cycles, then hit
//  5 inv pulse mid-fill of 0x8 -> handshake completes, 0x8 misses again;
//    inv in IDLE with hits on 0x0 -> next cycle 0x0 misses
//  6 rst low mid-fill -> bus_req=0, stall=1 immediately; late bus_ack ignored;
//    with IMEM_PERF_EN: tests 1-2 give miss_count=1, hit_count>=2, both 0 after rst

Source files
------------

// File: rtl/imem_ctrl.sv
// imem_ctrl: fetch-side instruction memory responder.
// Direct-mapped, one-word-per-line instruction cache in front of a
// variable-latency req/ack read bus.
// Optional macro IMEM_PERF_EN adds saturating hit_count/miss_count outputs.
module imem_ctrl #(
    parameter int unsigned LINES    = 16,
    parameter logic [31:0] RST_DATA = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic        inv,
    output logic [31:0] imem_data,
    output logic        stall,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
`ifdef IMEM_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t            state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES];
    logic              inv_pend_q, inv_pend_d;
    logic              bus_req_q, bus_req_d;
    logic [31:0]       bus_addr_q, bus_addr_d;

    logic [IDX_W-1:0]  idx, fill_idx;
    logic [TAG_W-1:0]  tag, fill_tag;
    logic              hit;
    logic              fill_we;
    logic              unused_addr_bits;

    assign idx      = imem_addr[IDX_W+1:2];
    assign tag      = imem_addr[31:IDX_W+2];
    assign fill_idx = bus_addr_q[IDX_W+1:2];
    assign fill_tag = bus_addr_q[31:IDX_W+2];

    // Byte offset of the PC is irrelevant for word fetches.
    assign unused_addr_bits = ^imem_addr[1:0];

    assign hit       = (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == tag);
    assign stall     = ~hit;
    assign imem_data = hit ? data_q[idx] : RST_DATA;
    assign bus_req   = bus_req_q;
    assign bus_addr  = bus_addr_q;

    // Next-state logic: launch a fill on miss, retire it on ack, track invalidates.
    always_comb begin
        state_d    = state_q;
        bus_req_d  = bus_req_q;
        bus_addr_d = bus_addr_q;
        inv_pend_d = inv_pend_q;
        fill_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!hit) begin
                    state_d    = FILL;
                    bus_req_d  = 1'b1;
                    bus_addr_d = {imem_addr[31:2], 2'b00};
                    inv_pend_d = inv;
                end
            end
            FILL: begin
                if (bus_ack) begin
                    state_d    = IDLE;
                    bus_req_d  = 1'b0;
                    inv_pend_d = 1'b0;
                    // An inv arriving in the ack cycle also suppresses the write,
                    // otherwise the line would survive the clear below.
                    fill_we    = ~inv_pend_q & ~inv;
                end else if (inv) begin
                    inv_pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d = valid_q;
        if (fill_we) begin
            valid_d[fill_idx] = 1'b1;
        end
        if (inv) begin
            valid_d = '0;
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            inv_pend_q <= 1'b0;
            bus_req_q  <= 1'b0;
            bus_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            inv_pend_q <= inv_pend_d;
            bus_req_q  <= bus_req_d;
            bus_addr_q <= bus_addr_d;
        end
    end

    // Tag/data arrays: written on a completed fill, never reset.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= bus_rdata;
        end
    end

`ifdef IMEM_PERF_EN
    logic [31:0] hit_count_q, miss_count_q;

    // Saturating performance counters; unaffected by invalidate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (hit && (hit_count_q != '1)) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if ((state_q == IDLE) && !hit && (miss_count_q != '1)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: directed bench for imem_ctrl with a word-address cache model.
// Define IMEM_PERF_EN for both files to also exercise the performance counters.
module tb_imem_ctrl;

    localparam int unsigned LINES    = 16;
    localparam logic [31:0] RST_DATA = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr = '0;
    logic        inv = 1'b0;
    logic [31:0] imem_data;
    logic        stall;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
`ifdef IMEM_PERF_EN
    logic [31:0] hit_count, miss_count;
`endif

    imem_ctrl #(.LINES(LINES), .RST_DATA(RST_DATA)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_addr (imem_addr),
        .inv       (inv),
        .imem_data (imem_data),
        .stall     (stall),
        .bus_req   (bus_req),
        .bus_addr  (bus_addr),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
`ifdef IMEM_PERF_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Backing memory: ack resp_delay cycles after bus_req is first seen high.
    int unsigned resp_delay = 0;
    int unsigned wait_cnt   = 0;
    logic [31:0] resp_data  = '0;
    logic        force_ack  = 1'b0;

    always @(posedge clk) begin
        #2;
        bus_ack   = force_ack;
        bus_rdata = force_ack ? 32'hBAD0_BAD0 : 32'h0;
        if (rst && bus_req && !force_ack) begin
            if (wait_cnt >= resp_delay) begin
                bus_ack   = 1'b1;
                bus_rdata = resp_data;
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Model: each line remembers the full word address it holds.
    logic        m_busy, m_pend, m_h;
    logic [31:0] m_addr;
    logic        m_valid [LINES];
    logic [29:0] m_word  [LINES];
    logic [31:0] m_data  [LINES];
    logic [31:0] m_hits, m_misses;

    function automatic logic model_hit();
        int unsigned k = int'(imem_addr[5:2]);
        return !m_busy && m_valid[k] && (m_word[k] == imem_addr[31:2]);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0; m_pend = 1'b0; m_addr = '0; m_hits = '0; m_misses = '0;
            for (int unsigned i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        end else begin
            m_h = model_hit();
            if (m_h && m_hits != 32'hFFFF_FFFF) m_hits++;
            if (!m_busy) begin
                if (!m_h) begin
                    m_busy = 1'b1;
                    m_addr = {imem_addr[31:2], 2'b00};
                    m_pend = inv;
                    if (m_misses != 32'hFFFF_FFFF) m_misses++;
                end
            end else if (bus_ack) begin
                if (!m_pend && !inv) begin
                    m_valid[int'(m_addr[5:2])] = 1'b1;
                    m_word[int'(m_addr[5:2])]  = m_addr[31:2];
                    m_data[int'(m_addr[5:2])]  = bus_rdata;
                end
                m_busy = 1'b0;
                m_pend = 1'b0;
            end else if (inv) begin
                m_pend = 1'b1;
            end
            if (inv) for (int unsigned i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    task automatic sample();
        logic eh;
        @(negedge clk);
        eh = model_hit();
        check("model stall", {31'b0, stall}, {31'b0, !eh});
        check("model imem_data", imem_data, eh ? m_data[int'(imem_addr[5:2])] : RST_DATA);
        check("model bus_req", {31'b0, bus_req}, {31'b0, m_busy});
        check("model bus_addr", bus_addr, m_addr);
`ifdef IMEM_PERF_EN
        check("model hit_count", hit_count, m_hits);
        check("model miss_count", miss_count, m_misses);
`endif
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int unsigned n);
        repeat (n) begin
            sample();
            advance();
        end
    endtask

    // Leaves the bench in the sampled hit cycle (not advanced).
    task automatic wait_hit(input string name, input int unsigned max);
        logic ok = 1'b0;
        int unsigned k = 0;
        while (!ok && k < max) begin
            sample();
            if (stall == 1'b0) ok = 1'b1;
            else advance();
            k++;
        end
        check(name, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        // Reset state
        sample();
        check("reset stall", {31'b0, stall}, 32'd1);
        check("reset imem_data", imem_data, RST_DATA);
        check("reset bus_req", {31'b0, bus_req}, 32'd0);
        check("reset bus_addr", bus_addr, 32'd0);
        advance();
        run(1);

        // 1: cold miss at 0x0, ack 3 cycles after req -> 5 stall cycles
        imem_addr = 32'h0; resp_delay = 3; resp_data = 32'hDEAD_BEEF;
        rst = 1'b1;
        for (int unsigned c = 0; c < 5; c++) begin
            sample();
            check("t1 stall", {31'b0, stall}, 32'd1);
            if (c == 1) begin
                check("t1 bus_req", {31'b0, bus_req}, 32'd1);
                check("t1 bus_addr", bus_addr, 32'h0);
            end
            advance();
        end
        sample();
        check("t1 hit stall", {31'b0, stall}, 32'd0);
        check("t1 hit data", imem_data, 32'hDEAD_BEEF);
        advance();

        // 2: re-present 0x0 -> hit, bus untouched
        sample();
        check("t2 stall", {31'b0, stall}, 32'd0);
        check("t2 data", imem_data, 32'hDEAD_BEEF);
        advance();
        sample();
        check("t2 bus_req", {31'b0, bus_req}, 32'd0);
        advance();
`ifdef IMEM_PERF_EN
        check("t2 miss_count", miss_count, 32'd1);
        check("t2 hit_count>=2", {31'b0, hit_count >= 32'd2}, 32'd1);
`endif

        // 3: conflicting tag on idx 0 replaces the line
        imem_addr = 32'h40; resp_delay = 1; resp_data = 32'h1234_5678;
        for (int unsigned c = 0; c < 3; c++) begin
            sample();
            check("t3 stall", {31'b0, stall}, 32'd1);
            if (c == 1) check("t3 bus_addr", bus_addr, 32'h40);
            advance();
        end
        sample();
        check("t3 hit data", imem_data, 32'h1234_5678);
        advance();
        imem_addr = 32'h0; resp_data = 32'hDEAD_BEEF;
        sample();
        check("t3 0x0 evicted", {31'b0, stall}, 32'd1);
        advance();
        sample();
        check("t3 refetch req", {31'b0, bus_req}, 32'd1);
        check("t3 refetch addr", bus_addr, 32'h0);
        advance();
        wait_hit("t3 refill timeout", 10);
        check("t3 refill data", imem_data, 32'hDEAD_BEEF);
        advance();

        // 4: unaligned PC, ack in the cycle bus_req rises -> 2 stall cycles
        imem_addr = 32'h7; resp_delay = 0; resp_data = 32'hA5A5_0007;
        sample();
        check("t4 miss stall", {31'b0, stall}, 32'd1);
        advance();
        sample();
        check("t4 fill stall", {31'b0, stall}, 32'd1);
        check("t4 bus_req", {31'b0, bus_req}, 32'd1);
        check("t4 bus_addr", bus_addr, 32'h4);
        check("t4 bus_ack", {31'b0, bus_ack}, 32'd1);
        advance();
        sample();
        check("t4 hit stall", {31'b0, stall}, 32'd0);
        check("t4 hit data", imem_data, 32'hA5A5_0007);
        advance();

        // 5a: inv during fill of 0x8 -> line not written
        imem_addr = 32'h8; resp_delay = 3; resp_data = 32'h0808_0808;
        run(1);
        inv = 1'b1;
        run(1);
        inv = 1'b0;
        begin
            logic seen = 1'b0;
            int unsigned k = 0;
            while (!seen && k < 10) begin
                sample();
                if (bus_ack) seen = 1'b1;
                advance();
                k++;
            end
            check("t5 ack timeout", {31'b0, seen}, 32'd1);
        end
        sample();
        check("t5 0x8 misses again", {31'b0, stall}, 32'd1);
        advance();
        sample();
        check("t5 refetch req", {31'b0, bus_req}, 32'd1);
        check("t5 refetch addr", bus_addr, 32'h8);
        advance();
        wait_hit("t5 refill timeout", 10);
        check("t5 refill data", imem_data, 32'h0808_0808);
        advance();

        // 5b: inv in IDLE while hitting 0x0
        imem_addr = 32'h0; resp_data = 32'hDEAD_BEEF;
        wait_hit("t5 fill0 timeout", 10);
        advance();
        inv = 1'b1;
        sample();
        check("t5 inv-cycle stall", {31'b0, stall}, 32'd0);
        check("t5 inv-cycle data", imem_data, 32'hDEAD_BEEF);
        advance();
        inv = 1'b0;
        sample();
        check("t5 post-inv stall", {31'b0, stall}, 32'd1);
        advance();
        wait_hit("t5 settle timeout", 10);
        advance();

        // 6: async reset mid-fill, stray ack afterwards ignored
        imem_addr = 32'h10; resp_delay = 50; resp_data = 32'h1010_1010;
        run(1);
        sample();
        check("t6 bus_req", {31'b0, bus_req}, 32'd1);
        check("t6 bus_addr", bus_addr, 32'h10);
        advance();
        run(2);
        rst = 1'b0;
        #1;
        check("t6 async bus_req", {31'b0, bus_req}, 32'd0);
        check("t6 async stall", {31'b0, stall}, 32'd1);
        check("t6 async data", imem_data, RST_DATA);
        check("t6 async bus_addr", bus_addr, 32'h0);
        sample();
        advance();
`ifdef IMEM_PERF_EN
        check("t6 rst hit_count", hit_count, 32'd0);
        check("t6 rst miss_count", miss_count, 32'd0);
`endif
        rst = 1'b1; force_ack = 1'b1; resp_delay = 2;
        sample();
        check("t6 stray ack stall", {31'b0, stall}, 32'd1);
        advance();
        force_ack = 1'b0;
        sample();
        check("t6 new fill req", {31'b0, bus_req}, 32'd1);
        check("t6 new fill addr", bus_addr, 32'h10);
        advance();
        wait_hit("t6 fill timeout", 10);
        check("t6 fill data", imem_data, 32'h1010_1010);
        advance();
        run(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
